// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared definitions for the fetch-stage PC sequencer.
package fetch_pc_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_pc_ctrl_if;

  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);

endinterface

// File: rtl/fetch_pc_ctrl_redirect_pending.sv
// Holds a redirect target whose delay slot has not been fetched yet, and
// selects the target that wins when the current instruction is accepted.
module fetch_pc_ctrl_redirect_pending (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        accept,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        take_target,
  output logic [31:0] target
);

  logic        pending_valid;
  logic [31:0] pending_target;

  // Capture a redirect that arrives before its delay slot is accepted; a
  // second redirect while one is pending is dropped so the first is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_valid  <= 1'b0;
      pending_target <= '0;
    end else if (accept && pending_valid) begin
      pending_valid  <= 1'b0;
    end else if (redirect_valid && !stall && !accept && !pending_valid) begin
      pending_valid  <= 1'b1;
      pending_target <= redirect_target;
    end
  end

  // A pending target outranks a live redirect on the accepting cycle.
  always_comb begin
    take_target = pending_valid || redirect_valid;
    target      = pending_valid ? pending_target : redirect_target;
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer: owns the PC, drives the imem handshake, applies
// hazard stalls and branch/jump redirects honouring the delay slot.
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall_i,
  input  logic                   redirect_valid_i,
  input  logic [31:0]            redirect_target_i,
  fetch_pc_ctrl_if.master        imem,
  output logic [31:0]            instr_f_o,
  output logic                   instr_valid_o,
  output logic [31:0]            pc_f_o,
  output logic [31:0]            pc8_f_o,
  output logic                   misalign_o
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  hold_buf;
  logic         misalign;
  logic         req;
  logic         valid;
  logic         accept;
  logic         take_target;
  logic [31:0]  target;

  fetch_pc_ctrl_redirect_pending u_pending (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall_i),
    .accept          (accept),
    .redirect_valid  (redirect_valid_i),
    .redirect_target (redirect_target_i),
    .take_target     (take_target),
    .target          (target)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  // Handshake outputs, accept, next state and next PC.
  always_comb begin
    req       = 1'b0;
    valid     = 1'b0;
    instr_f_o = NOP_WORD;
    state_nxt = state;
    if (!reset) begin
      if (state == FETCH) begin
        req   = 1'b1;
        valid = imem.ready;
        if (valid) instr_f_o = imem.rdata;
      end else begin
        valid     = 1'b1;
        instr_f_o = hold_buf;
      end
    end
    accept = valid && !stall_i;
    case (state)
      FETCH:   if (imem.ready && stall_i) state_nxt = HOLD;
      HOLD:    if (!stall_i)              state_nxt = FETCH;
      default:                            state_nxt = FETCH;
    endcase
    pc_nxt = pc;
    if (accept) pc_nxt = take_target ? target : pc + 32'd4;
  end

  // PC, hold buffer and sticky misalign flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      hold_buf <= '0;
      misalign <= 1'b0;
    end else begin
      pc <= pc_nxt;
      if (state == FETCH && imem.ready && stall_i) hold_buf <= imem.rdata;
      if (accept && take_target && target[1:0] != 2'b00) misalign <= 1'b1;
    end
  end

  assign imem.req      = req;
  assign imem.addr     = pc;
  assign instr_valid_o = valid;
  assign pc_f_o        = pc;
  assign pc8_f_o       = pc + 32'd8;
  assign misalign_o    = misalign;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: a scoreboard of the expected accepted-PC stream
// plus per-scenario inline checks.
module tb_fetch_pc_ctrl;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        rv;
  logic [31:0] rt;
  logic        ready;
  logic [31:0] instr_f;
  logic        instr_valid;
  logic [31:0] pc_f;
  logic [31:0] pc8_f;
  logic        misalign;

  int vectors;
  int miscompares;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  fetch_pc_ctrl_if imem ();

  fetch_pc_ctrl #(.RESET_PC(32'h0000_3000)) dut (
    .clk               (clk),
    .reset             (reset),
    .stall_i           (stall),
    .redirect_valid_i  (rv),
    .redirect_target_i (rt),
    .imem              (imem),
    .instr_f_o         (instr_f),
    .instr_valid_o     (instr_valid),
    .pc_f_o            (pc_f),
    .pc8_f_o           (pc8_f),
    .misalign_o        (misalign)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign imem.ready = ready;
  assign imem.rdata = ready ? mem_word(imem.addr) : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every accepted instruction must match the next expected PC.
  always @(negedge clk) begin
    if (!reset && instr_valid && !stall) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL accept_unexpected: got pc %h, required no accept", pc_f);
      end else begin
        mon_exp = exp_q.pop_front();
        if (pc_f !== mon_exp || instr_f !== mem_word(mon_exp)) begin
          miscompares++;
          $display("FAIL accept_stream: got pc %h instr %h, required pc %h instr %h",
                   pc_f, instr_f, mon_exp, mem_word(mon_exp));
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; rv = 1'b0; rt = '0; ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (imem.req !== 1'b0 || instr_valid !== 1'b0 || instr_f !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got req %b valid %b instr %h, required 0 0 0",
               imem.req, instr_valid, instr_f);
    end
    next_cycle();
    reset = 1'b0;
    exp_q.push_back(32'h3000);
    @(negedge clk);
    vectors++;
    if (imem.req !== 1'b1 || imem.addr !== 32'h3000 || pc8_f !== 32'h3008 || misalign !== 1'b0) begin
      miscompares++;
      $display("FAIL first_fetch: got req %b addr %h pc8 %h mis %b, required 1 00003000 00003008 0",
               imem.req, imem.addr, pc8_f, misalign);
    end
    next_cycle();
  endtask

  task automatic test_sequential();
    exp_q.push_back(32'h3004);
    exp_q.push_back(32'h3008);
    @(negedge clk);
    vectors++;
    if (imem.addr !== 32'h3004) begin
      miscompares++;
      $display("FAIL seq_addr1: got %h, required 00003004", imem.addr);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if (imem.addr !== 32'h3008 || pc8_f !== 32'h3010) begin
      miscompares++;
      $display("FAIL seq_addr2: got addr %h pc8 %h, required 00003008 00003010", imem.addr, pc8_f);
    end
    next_cycle();
  endtask

  task automatic test_stall();
    stall = 1'b1; ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b1 || imem.req !== 1'b1 || pc_f !== 32'h300C) begin
      miscompares++;
      $display("FAIL stall_fetch: got valid %b req %b pc %h, required 1 1 0000300c",
               instr_valid, imem.req, pc_f);
    end
    next_cycle();
    ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (imem.req !== 1'b0 || instr_valid !== 1'b1 || pc_f !== 32'h300C ||
        instr_f !== mem_word(32'h300C)) begin
      miscompares++;
      $display("FAIL stall_hold: got req %b valid %b pc %h instr %h, required 0 1 0000300c %h",
               imem.req, instr_valid, pc_f, instr_f, mem_word(32'h300C));
    end
    next_cycle();
    stall = 1'b0;
    exp_q.push_back(32'h300C);
    next_cycle();
    ready = 1'b1;
    exp_q.push_back(32'h3010);
    @(negedge clk);
    vectors++;
    if (imem.addr !== 32'h3010 || imem.req !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release: got addr %h req %b, required 00003010 1", imem.addr, imem.req);
    end
    next_cycle();
  endtask

  task automatic test_redirect_accept();
    rv = 1'b1; rt = 32'h3100;
    exp_q.push_back(32'h3014);
    next_cycle();
    rv = 1'b0;
    exp_q.push_back(32'h3100);
    @(negedge clk);
    vectors++;
    if (imem.addr !== 32'h3100) begin
      miscompares++;
      $display("FAIL redirect_accept: got addr %h, required 00003100", imem.addr);
    end
    next_cycle();
  endtask

  task automatic test_redirect_wait();
    ready = 1'b0; rv = 1'b1; rt = 32'h3200;
    @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b0 || instr_f !== 32'h0 || imem.addr !== 32'h3104) begin
      miscompares++;
      $display("FAIL wait_nop: got valid %b instr %h addr %h, required 0 00000000 00003104",
               instr_valid, instr_f, imem.addr);
    end
    next_cycle();
    rv = 1'b0;
    @(negedge clk);
    vectors++;
    if (imem.addr !== 32'h3104 || imem.req !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_addr_stable: got addr %h req %b, required 00003104 1", imem.addr, imem.req);
    end
    next_cycle();
    ready = 1'b1;
    exp_q.push_back(32'h3104);
    next_cycle();
    exp_q.push_back(32'h3200);
    @(negedge clk);
    vectors++;
    if (imem.addr !== 32'h3200) begin
      miscompares++;
      $display("FAIL pending_target: got addr %h, required 00003200", imem.addr);
    end
    next_cycle();
    exp_q.push_back(32'h3204);
    next_cycle();
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1; rv = 1'b1; rt = 32'h3300; ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (pc_f !== 32'h3208) begin
      miscompares++;
      $display("FAIL stall_redirect_pc: got %h, required 00003208", pc_f);
    end
    next_cycle();
    stall = 1'b0; rt = 32'h3100;
    exp_q.push_back(32'h3208);
    @(negedge clk);
    vectors++;
    if (pc_f !== 32'h3208 || instr_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_redirect_hold: got pc %h valid %b, required 00003208 1", pc_f, instr_valid);
    end
    next_cycle();
    rv = 1'b0;
    exp_q.push_back(32'h3100);
    @(negedge clk);
    vectors++;
    if (imem.addr !== 32'h3100) begin
      miscompares++;
      $display("FAIL stall_redirect_target: got addr %h, required 00003100", imem.addr);
    end
    next_cycle();
  endtask

  task automatic test_misalign();
    rv = 1'b1; rt = 32'h3102;
    exp_q.push_back(32'h3104);
    @(negedge clk);
    vectors++;
    if (misalign !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign_pre: got %b, required 0", misalign);
    end
    next_cycle();
    rv = 1'b0;
    exp_q.push_back(32'h3102);
    @(negedge clk);
    vectors++;
    if (imem.addr !== 32'h3102 || misalign !== 1'b1 || pc8_f !== 32'h310A) begin
      miscompares++;
      $display("FAIL misalign_set: got addr %h mis %b pc8 %h, required 00003102 1 0000310a",
               imem.addr, misalign, pc8_f);
    end
    next_cycle();
    exp_q.push_back(32'h3106);
    @(negedge clk);
    vectors++;
    if (misalign !== 1'b1) begin
      miscompares++;
      $display("FAIL misalign_sticky: got %b, required 1", misalign);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_hold();
    ready = 1'b0; rv = 1'b1; rt = 32'h3400;
    next_cycle();
    rv = 1'b0; ready = 1'b1; stall = 1'b1;
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b0 || imem.req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_hold: got valid %b req %b, required 0 0", instr_valid, imem.req);
    end
    next_cycle();
    reset = 1'b0; stall = 1'b0;
    exp_q.push_back(32'h3000);
    @(negedge clk);
    vectors++;
    if (imem.addr !== 32'h3000 || imem.req !== 1'b1 || misalign !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_restart: got addr %h req %b mis %b, required 00003000 1 0",
               imem.addr, imem.req, misalign);
    end
    next_cycle();
    exp_q.push_back(32'h3004);
    @(negedge clk);
    vectors++;
    if (imem.addr !== 32'h3004) begin
      miscompares++;
      $display("FAIL pending_discarded: got addr %h, required 00003004", imem.addr);
    end
    next_cycle();
  endtask

  task automatic test_wrap();
    rv = 1'b1; rt = 32'hFFFF_FFFC;
    exp_q.push_back(32'h3008);
    next_cycle();
    rv = 1'b0;
    exp_q.push_back(32'hFFFF_FFFC);
    @(negedge clk);
    vectors++;
    if (pc8_f !== 32'h0000_0004) begin
      miscompares++;
      $display("FAIL pc8_wrap: got %h, required 00000004", pc8_f);
    end
    next_cycle();
    exp_q.push_back(32'h0000_0000);
    @(negedge clk);
    vectors++;
    if (imem.addr !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL pc_wrap: got %h, required 00000000", imem.addr);
    end
    next_cycle();
    stall = 1'b1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_accept();
    test_redirect_wait();
    test_redirect_stall();
    test_misalign();
    test_reset_mid_hold();
    test_wrap();
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
